// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the RV32I memory subsystem RAMs.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : values for the RDW_MODE parameter
//   init_state_t                     : clear-sweep FSM encoding (ST_INIT, ST_READY)
//   merge_be()                       : byte-strobe merge of a new word into an old word
// merge_be works on a wide container (MERGE_W bits) so any DATA_W up to
// MERGE_W can use it; callers zero-extend the inputs and truncate the result.
package rv_mem_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_t;

    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    // Bytes whose strobe bit is set come from new_word, the rest from old_word.
    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tdp_ram_be_if.sv
// tdp_ram_be_if: request/response bundle for both ports of tdp_ram_be.
//   a_en/b_en       access request
//   a_we/b_we       byte write strobes, all-zero = read
//   a_addr/b_addr   word address
//   a_wdata/b_wdata write data
//   a_rdata/b_rdata read data        (driven by the RAM)
//   a_rvalid/b_rvalid read data valid (driven by the RAM)
// master = requester side, slave = RAM side.
interface tdp_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    localparam int BE_W = DATA_W / 8;

    logic              a_en;
    logic [BE_W-1:0]   a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_en;
    logic [BE_W-1:0]   b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    modport master (
        output a_en, a_we, a_addr, a_wdata,
        output b_en, b_we, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid
    );

    modport slave (
        input  a_en, a_we, a_addr, a_wdata,
        input  b_en, b_we, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_rdata, b_rvalid
    );
endinterface

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset clear sequencer for tdp_ram_be.
//   clk        clock
//   rst        synchronous active-high reset; restarts the sweep from address 0
//   init_busy  high while the sweep runs (exactly 2**ADDR_W cycles after rst falls)
//   sweep_addr address written with the init value in the current cycle
module ram_init_seq
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic [ADDR_W-1:0] sweep_addr
);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // Last address written this cycle; counter wraps back to 0.
                if (cnt_q == '1) state_d = ST_READY;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    assign sweep_addr = cnt_q;

endmodule

// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true-dual-port RAM with per-byte write strobes and a
// post-reset clear sweep that fills every word with INIT_VALUE.
//   clk        single clock for both ports
//   rst        synchronous active-high reset
//   bus        tdp_ram_be_if.slave: port A (fetch) and port B (LSU) requests/responses
//   init_busy  clear sweep running; all requests are ignored
//   coll       one-cycle pulse after both ports wrote the same address
// Same-address writes merge per byte, port A winning overlapping bytes.
// A read racing a write from the other port returns the pre-write word.
// Optional build macro TDP_RAM_OUT_REG_EN: extra output register on both
// ports (read latency 2 instead of 1); rvalid is delayed alongside rdata.
module tdp_ram_be
    import rv_mem_pkg::*;
#(
    parameter int                  DATA_W     = 32,
    parameter int                  ADDR_W     = 10,
    parameter int                  RDW_MODE   = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0]   INIT_VALUE = '0
) (
    input  logic      clk,
    input  logic      rst,
    tdp_ram_be_if.slave bus,
    output logic      init_busy,
    output logic      coll
);

    localparam int BE_W        = DATA_W / 8;
    localparam int DEPTH       = 2 ** ADDR_W;
    localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(merge_be(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_BE_W'(be)));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] sweep_addr;

    ram_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
        .clk        (clk),
        .rst        (rst),
        .init_busy  (init_busy),
        .sweep_addr (sweep_addr)
    );

    logic              a_wr, b_wr, a_rd, b_rd, wr_same;
    logic [DATA_W-1:0] a_wr_word, b_wr_word, a_rd_word, b_rd_word;

    always_comb begin
        a_wr      = !init_busy && bus.a_en && (bus.a_we != '0);
        b_wr      = !init_busy && bus.b_en && (bus.b_we != '0);
        a_rd      = !init_busy && bus.a_en && (bus.a_we == '0);
        b_rd      = !init_busy && bus.b_en && (bus.b_we == '0);
        wr_same   = a_wr && b_wr && (bus.a_addr == bus.b_addr);
        b_wr_word = merge_word(mem[bus.b_addr], bus.b_wdata, bus.b_we);
        // On a same-address collision A merges on top of B's result, so A wins shared bytes.
        a_wr_word = merge_word(wr_same ? b_wr_word : mem[bus.a_addr], bus.a_wdata, bus.a_we);
        // A port never reads and writes in one cycle, so the write-first bypass
        // never selects; cross-port reads always see the pre-edge array contents.
        a_rd_word = (WRITE_FIRST && a_wr) ? a_wr_word : mem[bus.a_addr];
        b_rd_word = (WRITE_FIRST && b_wr) ? b_wr_word : mem[bus.b_addr];
    end

    // NOTE: the array itself has no reset; the clear sweep initialises it after every rst.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else begin
            if (a_wr)             mem[bus.a_addr] <= a_wr_word;
            if (b_wr && !wr_same) mem[bus.b_addr] <= b_wr_word;
        end
    end

    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_rvalid_q, b_rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            coll       <= 1'b0;
        end else begin
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            if (a_rd) a_rdata_q <= a_rd_word;
            if (b_rd) b_rdata_q <= b_rd_word;
            coll       <= wr_same;
        end
    end

`ifdef TDP_RAM_OUT_REG_EN
    logic [DATA_W-1:0] a_rdata_q2, b_rdata_q2;
    logic              a_rvalid_q2, b_rvalid_q2;

    // First stage holds between reads, so a plain copy keeps rdata held here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q2  <= '0;
            b_rdata_q2  <= '0;
            a_rvalid_q2 <= 1'b0;
            b_rvalid_q2 <= 1'b0;
        end else begin
            a_rdata_q2  <= a_rdata_q;
            b_rdata_q2  <= b_rdata_q;
            a_rvalid_q2 <= a_rvalid_q;
            b_rvalid_q2 <= b_rvalid_q;
        end
    end

    assign bus.a_rdata  = a_rdata_q2;
    assign bus.b_rdata  = b_rdata_q2;
    assign bus.a_rvalid = a_rvalid_q2;
    assign bus.b_rvalid = b_rvalid_q2;
`else
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
`endif

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb_tdp_ram_be: directed, table-driven bench for tdp_ram_be (DATA_W=32, ADDR_W=4).
// Follows TDP_RAM_OUT_REG_EN to pick the expected read latency.
module tb_tdp_ram_be;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 4;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] INIT_VAL = 32'hA5A5_0F0F;
`ifdef TDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_busy, coll;

    tdp_ram_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    tdp_ram_be #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RDW_MODE   (0),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_busy (init_busy),
        .coll      (coll)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_addr,
                         input logic [31:0] a_wdata, input logic b_en, input logic [3:0] b_we,
                         input logic [3:0] b_addr, input logic [31:0] b_wdata);
        bus.a_en = a_en; bus.a_we = a_we; bus.a_addr = a_addr; bus.a_wdata = a_wdata;
        bus.b_en = b_en; bus.b_we = b_we; bus.b_addr = b_addr; bus.b_wdata = b_wdata;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    typedef struct {
        logic        a_en;
        logic [3:0]  a_we;
        logic [3:0]  a_addr;
        logic [31:0] a_wdata;
        logic        b_en;
        logic [3:0]  b_we;
        logic [3:0]  b_addr;
        logic [31:0] b_wdata;
        logic        a_rv;
        logic [31:0] a_rd;
        logic        b_rv;
        logic [31:0] b_rd;
        logic        coll;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          busy_pre;
        int          bad_ack;
        logic [31:0] last_a, last_b, exp_a, exp_b;

        vecs[0]  = '{1, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd15, 32'h0,        1, INIT_VAL,     1, INIT_VAL,     0};
        vecs[1]  = '{1, 4'hF, 4'd3, 32'hDEADBEEF, 1, 4'hF, 4'd5,  32'h0,        0, 32'h0,        0, 32'h0,        0};
        vecs[2]  = '{1, 4'h0, 4'd3, 32'h0,        1, 4'h0, 4'd5,  32'h0,        1, 32'hDEADBEEF, 1, 32'h0,        0};
        vecs[3]  = '{1, 4'h3, 4'd5, 32'h11223344, 1, 4'h6, 4'd5,  32'hAABBCCDD, 0, 32'h0,        0, 32'h0,        1};
        vecs[4]  = '{1, 4'h0, 4'd5, 32'h0,        1, 4'h0, 4'd3,  32'h0,        1, 32'h00BB3344, 1, 32'hDEADBEEF, 0};
        vecs[5]  = '{1, 4'h0, 4'd9, 32'h0,        1, 4'h8, 4'd9,  32'h12345678, 1, INIT_VAL,     0, 32'h0,        0};
        vecs[6]  = '{1, 4'h0, 4'd9, 32'h0,        1, 4'h1, 4'd9,  32'hFFFFFF77, 1, 32'h12A50F0F, 0, 32'h0,        0};
        vecs[7]  = '{1, 4'hC, 4'd9, 32'hCAFE0000, 1, 4'h0, 4'd9,  32'h0,        0, 32'h0,        1, 32'h12A50F77, 0};
        vecs[8]  = '{1, 4'h0, 4'd9, 32'h0,        1, 4'h0, 4'd9,  32'h0,        1, 32'hCAFE0F77, 1, 32'hCAFE0F77, 0};
        vecs[9]  = '{0, 4'hF, 4'd9, 32'h0,        0, 4'h0, 4'd9,  32'h0,        0, 32'h0,        0, 32'h0,        0};
        vecs[10] = '{1, 4'h0, 4'd9, 32'h0,        1, 4'h0, 4'd9,  32'h0,        1, 32'hCAFE0F77, 1, 32'hCAFE0F77, 0};
        vecs[11] = '{1, 4'h1, 4'd1, 32'h00000001, 1, 4'h1, 4'd2,  32'h00000002, 0, 32'h0,        0, 32'h0,        0};
        vecs[12] = '{1, 4'h0, 4'd1, 32'h0,        1, 4'h0, 4'd2,  32'h0,        1, 32'hA5A50F01, 1, 32'hA5A50F02, 0};
        vecs[13] = '{1, 4'hF, 4'd4, 32'h11111111, 1, 4'hF, 4'd4,  32'h22222222, 0, 32'h0,        0, 32'h0,        1};
        vecs[14] = '{1, 4'h0, 4'd4, 32'h0,        1, 4'h0, 4'd4,  32'h0,        1, 32'h11111111, 1, 32'h11111111, 0};

        // Reset state.
        idle();
        repeat (3) step();
        check("rst_a_rdata", bus.a_rdata, 32'h0);
        check("rst_b_rdata", bus.b_rdata, 32'h0);
        check("rst_a_rvalid", 32'(bus.a_rvalid), 32'h0);
        check("rst_b_rvalid", 32'(bus.b_rvalid), 32'h0);
        check("rst_coll", 32'(coll), 32'h0);
        check("rst_init_busy", 32'(init_busy), 32'h1);

        // Start a sweep, abort it at count 5, then time the restarted sweep.
        rst = 1'b0;
        busy_pre = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (init_busy) busy_pre++;
        end
        check("sweep_busy_before_abort", 32'(busy_pre), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Requests while busy must be ignored: no write, no rvalid, no coll.
        drive(1'b1, 4'hF, 4'd0, 32'hFFFFFFFF, 1'b1, 4'h0, 4'd0, 32'h0);
        n = 0;
        bad_ack = 0;
        while (init_busy && n < 100) begin
            if (bus.a_rvalid || bus.b_rvalid || coll) bad_ack++;
            n++;
            step();
        end
        check("init_busy_cycles", 32'(n), 32'(DEPTH));
        check("busy_requests_acked", 32'(bad_ack), 32'h0);
        idle();
        repeat (2) step();
        check("post_init_a_rvalid", 32'(bus.a_rvalid), 32'h0);
        check("post_init_b_rvalid", 32'(bus.b_rvalid), 32'h0);
        check("post_init_a_rdata_hold", bus.a_rdata, 32'h0);
        check("post_init_b_rdata_hold", bus.b_rdata, 32'h0);

        // Every word holds INIT_VALUE after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
            step();
            idle();
            repeat (LAT - 1) step();
            check($sformatf("init_rd_a[%0d]", i), bus.a_rdata, INIT_VAL);
            check($sformatf("init_rd_b[%0d]", DEPTH - 1 - i), bus.b_rdata, INIT_VAL);
        end

        // Table of single-cycle transactions.
        last_a = INIT_VAL;
        last_b = INIT_VAL;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
                  vecs[i].b_en, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
            step();
            check($sformatf("v%0d_coll", i), 32'(coll), 32'(vecs[i].coll));
            idle();
            repeat (LAT - 1) step();
            exp_a = vecs[i].a_rv ? vecs[i].a_rd : last_a;
            exp_b = vecs[i].b_rv ? vecs[i].b_rd : last_b;
            check($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].a_rv));
            check($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].b_rv));
            check($sformatf("v%0d_a_rdata", i), bus.a_rdata, exp_a);
            check($sformatf("v%0d_b_rdata", i), bus.b_rdata, exp_b);
            last_a = exp_a;
            last_b = exp_b;
        end

        // A writes, B reads the same word in the very next cycle.
        drive(1'b1, 4'hF, 4'd6, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
        step();
        check("wr_then_rd_b_rvalid_wrcycle", 32'(bus.b_rvalid), 32'h0);
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd6, 32'h0);
        step();
        check("wr_then_rd_b_rvalid_lat", 32'(bus.b_rvalid), 32'(LAT == 1));
        idle();
        repeat (LAT - 1) step();
        check("wr_then_rd_b_rvalid", 32'(bus.b_rvalid), 32'h1);
        check("wr_then_rd_b_rdata", bus.b_rdata, 32'hDEADBEEF);
        step();
        check("wr_then_rd_b_rvalid_pulse", 32'(bus.b_rvalid), 32'h0);
        check("wr_then_rd_b_rdata_hold", bus.b_rdata, 32'hDEADBEEF);

        // Cross-port race: A writes 5 to addr 7 while B reads it (old 0).
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd7, 32'h0);
        step();
        drive(1'b1, 4'hF, 4'd7, 32'h00000005, 1'b1, 4'h0, 4'd7, 32'h0);
        step();
        idle();
        repeat (LAT - 1) step();
        check("race_b_rvalid", 32'(bus.b_rvalid), 32'h1);
        check("race_b_rdata_old", bus.b_rdata, 32'h0);
        check("race_a_rvalid_on_write", 32'(bus.a_rvalid), 32'h0);
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        step();
        idle();
        repeat (LAT - 1) step();
        check("race_b_rdata_new", bus.b_rdata, 32'h00000005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
